// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and address-split helpers for the L1 data cache.
// Holds the controller state enum, offset/word-select widths and index/tag width functions.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE,
    REFILL
  } state_t;

  localparam int OFFSET_W   = 5;
  localparam int WORD_SEL_W = 3;

  function automatic int index_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int lines);
    return addr_w - OFFSET_W - $clog2(lines);
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// dcache_sram: tag/valid/dirty/data arrays, async read, sync write.
// Ports: idx selects the line; line_we refills a line (valid=1, dirty=0); word_we writes a word and sets dirty.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int LINES     = 32,
  parameter int LINE_BITS = 256,
  parameter int IDX_W     = 5,
  parameter int TAG_W     = 22
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_W-1:0]      idx,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [LINE_BITS-1:0]  rd_line,
  input  logic                  line_we,
  input  logic [TAG_W-1:0]      line_tag,
  input  logic [LINE_BITS-1:0]  line_data,
  input  logic                  word_we,
  input  logic [WORD_SEL_W-1:0] word_sel,
  input  logic [31:0]           word_data
);

  logic [LINES-1:0]     valid;
  logic [LINES-1:0]     dirty;
  logic [TAG_W-1:0]     tags [LINES];
  logic [LINE_BITS-1:0] data [LINES];

  assign rd_valid = valid[idx];
  assign rd_dirty = dirty[idx];
  assign rd_tag   = tags[idx];
  assign rd_line  = data[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else if (line_we) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (word_we) begin
      dirty[idx] <= 1'b1;
    end
  end

  // Tag and data arrays are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tags[idx] <= line_tag;
      data[idx] <= line_data;
    end else if (word_we) begin
      data[idx][{word_sel, 5'd0} +: 32] <= word_data;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped write-back/write-allocate L1 D-cache controller.
// Ports: p1_* pipeline side, mem_* line-wide memory side, hit/miss counters (DCACHE_PERF_CNT_EN).
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int LINES     = 32,
  parameter int LINE_BITS = 256,
  parameter int ADDR_W    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 p1_req_i,
  input  logic                 p1_write_i,
  input  logic [ADDR_W-1:0]    p1_addr_i,
  input  logic [31:0]          p1_data_i,
  output logic [31:0]          p1_data_o,
  output logic                 p1_stall_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i,
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o
);

  localparam int IDX_W = index_w(LINES);
  localparam int TAG_W = tag_w(ADDR_W, LINES);

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic [WORD_SEL_W-1:0] word;
  logic                  v, d, hit;
  logic [TAG_W-1:0]      rd_tag;
  logic [LINE_BITS-1:0]  rd_line;
  logic                  line_we, word_we;
  logic                  unused_addr;
  state_t                state, state_n;

  assign idx  = p1_addr_i[OFFSET_W +: IDX_W];
  assign tag  = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign word = p1_addr_i[2 +: WORD_SEL_W];
  assign unused_addr = ^p1_addr_i[1:0];

  assign hit       = v & (rd_tag == tag);
  assign p1_data_o = rd_line[{word, 5'd0} +: 32];
  assign p1_stall_o = (state != IDLE) | (p1_req_i & ~hit);

  // Reset wins over an ack or store landing on the same edge.
  assign line_we = (state == ALLOCATE) & mem_ack_i & ~rst_i;
  assign word_we = (state == IDLE) & p1_req_i & p1_write_i
                 & hit & ~rst_i;

  dcache_sram #(
    .LINES(LINES), .LINE_BITS(LINE_BITS),
    .IDX_W(IDX_W), .TAG_W(TAG_W)
  ) u_sram (
    .clk(clk_i), .rst(rst_i), .idx(idx),
    .rd_valid(v), .rd_dirty(d),
    .rd_tag(rd_tag), .rd_line(rd_line),
    .line_we(line_we), .line_tag(tag),
    .line_data(mem_data_i),
    .word_we(word_we), .word_sel(word),
    .word_data(p1_data_i)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (p1_req_i && !hit)
          state_n = (v && d) ? WRITEBACK : ALLOCATE;
      WRITEBACK:
        if (mem_ack_i) state_n = ALLOCATE;
      ALLOCATE:
        if (mem_ack_i) state_n = REFILL;
      REFILL:
        state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  // Memory request registered from the upcoming state so it is
  // glitch-free and constant across the transfer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      mem_enable_o <= (state_n == WRITEBACK)
                    | (state_n == ALLOCATE);
      mem_write_o  <= (state_n == WRITEBACK);
      if (state_n == WRITEBACK)
        mem_addr_o <= {rd_tag, idx, 5'd0};
      else if (state_n == ALLOCATE)
        mem_addr_o <= {tag, idx, 5'd0};
      else
        mem_addr_o <= '0;
      mem_data_o <= (state_n == WRITEBACK) ? rd_line : '0;
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hits, misses;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hits   <= '0;
      misses <= '0;
    end else begin
      if (state == IDLE && p1_req_i && hit)
        hits <= hits + 32'd1;
      if (state == IDLE && state_n != IDLE)
        misses <= misses + 32'd1;
    end
  end

  assign hit_cnt_o  = hits;
  assign miss_cnt_o = misses;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: randomized scoreboard bench for dcache_controller.
// Flat-memory reference model, 10-cycle memory responder, DCACHE_PERF_CNT_EN aware.
module tb_dcache_controller;

  localparam int LINES = 32;
  localparam int LB    = 256;
  localparam int AW    = 32;
  localparam int LAT   = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          p1_req = 1'b0, p1_write = 1'b0;
  logic [AW-1:0] p1_addr = '0;
  logic [31:0]   p1_wdata = '0;
  logic [31:0]   p1_rdata;
  logic          p1_stall;
  logic          mem_enable, mem_write;
  logic [AW-1:0] mem_addr;
  logic [LB-1:0] mem_wdata;
  logic [LB-1:0] mem_rdata = '0;
  logic          model_ack = 1'b0, extra_ack = 1'b0;
  logic          mem_ack;
  logic [31:0]   hit_cnt, miss_cnt;

  assign mem_ack = model_ack | extra_ack;

  always #5 clk = ~clk;

  dcache_controller #(.LINES(LINES), .LINE_BITS(LB), .ADDR_W(AW)) dut (
    .clk_i(clk), .rst_i(rst),
    .p1_req_i(p1_req), .p1_write_i(p1_write),
    .p1_addr_i(p1_addr), .p1_data_i(p1_wdata),
    .p1_data_o(p1_rdata), .p1_stall_o(p1_stall),
    .mem_enable_o(mem_enable), .mem_write_o(mem_write),
    .mem_addr_o(mem_addr), .mem_data_o(mem_wdata),
    .mem_data_i(mem_rdata), .mem_ack_i(mem_ack),
    .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );

  int checks = 0;
  int fails  = 0;

  function automatic void check(string name, logic [31:0] got,
                                logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, got, want, $time);
    end
  endfunction

  // Reference: the cache must be invisible, so loads see a flat memory.
  logic [31:0] ref_mem  [logic [31:0]];
  logic [31:0] main_mem [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] rd_main(input logic [31:0] a);
    return main_mem.exists(a) ? main_mem[a] : init_word(a);
  endfunction

  // Which memory line each slot holds, for expected latency only.
  bit          r_valid [LINES];
  bit          r_dirty [LINES];
  int unsigned r_line  [LINES];
  int          exp_hits = 0, exp_misses = 0;
  logic [31:0] exp_wb_addr = '0, exp_rf_addr = '0;

  typedef struct {
    bit          load;
    logic [31:0] data;
    int          stalls;
  } exp_t;
  exp_t q[$];

  // Memory responder: ack in the LAT-th cycle of each request.
  int cnt = 0;
  always @(negedge clk) begin
    model_ack = 1'b0;
    if (!mem_enable) cnt = 0;
    else begin
      cnt++;
      for (int w = 0; w < 8; w++)
        mem_rdata[w*32 +: 32] = rd_main(mem_addr + 32'(4*w));
      if (cnt == LAT) begin
        model_ack = 1'b1;
        cnt = 0;
        check("mem_addr_align", 32'(mem_addr[4:0]), 32'd0);
        if (mem_write) begin
          check("wb_addr", mem_addr, exp_wb_addr);
          for (int w = 0; w < 8; w++) begin
            check("wb_word", mem_wdata[w*32 +: 32],
                  rd_ref(mem_addr + 32'(4*w)));
            main_mem[mem_addr + 32'(4*w)] = mem_wdata[w*32 +: 32];
          end
        end else begin
          check("refill_addr", mem_addr, exp_rf_addr);
        end
      end
    end
  end

  // Monitor: an access completes on the first unstalled request cycle.
  int run = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst || !p1_req) run = 0;
    else if (p1_stall) run++;
    else begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_completion: got 1 expected 0");
      end else begin
        e = q.pop_front();
        check("stall_cycles", 32'(run), 32'(e.stalls));
        check("mem_idle", 32'(mem_enable), 32'd0);
        if (e.load) check("load_data", p1_rdata, e.data);
      end
      run = 0;
    end
  end

  task automatic access(input bit wr, input logic [31:0] a,
                        input logic [31:0] d);
    exp_t        e;
    int          s;
    int unsigned la;
    bit          h;
    la = a >> 5;
    s  = int'(la % LINES);
    h  = r_valid[s] && r_line[s] == la;
    e.load   = !wr;
    e.data   = rd_ref(a);
    e.stalls = h ? 0
             : (r_valid[s] && r_dirty[s]) ? 2 + 2*LAT : 2 + LAT;
    if (!h) begin
      exp_wb_addr = r_line[s] << 5;
      exp_rf_addr = la << 5;
      exp_misses++;
      r_valid[s] = 1'b1;
      r_dirty[s] = 1'b0;
      r_line[s]  = la;
    end
    if (wr) begin
      ref_mem[a] = d;
      r_dirty[s] = 1'b1;
    end
    exp_hits++;
    q.push_back(e);
    p1_req = 1'b1; p1_write = wr; p1_addr = a; p1_wdata = d;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (!p1_stall) break;
      if (n > 100) begin
        check("access_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    p1_req = 1'b0;
    p1_write = 1'b0;
  endtask

  task automatic check_counters(string tag);
`ifdef DCACHE_PERF_CNT_EN
    check({tag, "_hit_cnt"}, hit_cnt, 32'(exp_hits));
    check({tag, "_miss_cnt"}, miss_cnt, 32'(exp_misses));
`else
    check({tag, "_hit_cnt"}, hit_cnt, 32'd0);
    check({tag, "_miss_cnt"}, miss_cnt, 32'd0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mem_enable", 32'(mem_enable), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_data", 32'(mem_wdata != '0), 32'd0);
    check("rst_stall", 32'(p1_stall), 32'd0);
    check_counters("rst");

    access(1'b0, 32'h000, 32'h0);
    access(1'b1, 32'h004, 32'hDEADBEEF);
    access(1'b0, 32'h004, 32'h0);
    access(1'b0, 32'h400, 32'h0);
    check_counters("directed");

    // Abort a refill of line 0x00 in its fourth cycle.
    p1_req = 1'b1; p1_write = 1'b0; p1_addr = 32'h000;
    for (int n = 0; n < 20 && !mem_enable; n++) @(negedge clk);
    check("abort_alloc_started", 32'(mem_enable), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    p1_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("abort_mem_enable", 32'(mem_enable), 32'd0);
    for (int i = 0; i < LINES; i++) begin
      r_valid[i] = 1'b0;
      r_dirty[i] = 1'b0;
    end
    exp_hits = 0;
    exp_misses = 0;
    check_counters("abort");
    extra_ack = 1'b1;
    @(negedge clk);
    extra_ack = 1'b0;
    @(negedge clk);
    check("spurious_ack_enable", 32'(mem_enable), 32'd0);
    check("spurious_ack_stall", 32'(p1_stall), 32'd0);
    @(posedge clk);
    #1;

    access(1'b0, 32'h000, 32'h0);
    access(1'b0, 32'h004, 32'h0);
    access(1'b0, 32'h400, 32'h0);

    for (int i = 0; i < 150; i++) begin
      a = (32'($urandom_range(0, 3)) << 10)
        | (32'($urandom_range(0, 3)) << 5)
        | (32'($urandom_range(0, 7)) << 2);
      access(1'($urandom_range(0, 1)), a, $urandom);
    end
    check_counters("final");
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
